// File: rtl/arm_mem_stage_sram_if.sv
`default_nettype none
// ============================================================================
//  Module   : arm_mem_stage_sram_if
//  Purpose  : Bus between the ARM pipeline (EXE/MEM -> MEM/WB) and the
//             multi-cycle data-memory MEM stage.
//  Signals  : mem_r_en  load request            (pipeline -> memory)
//             mem_w_en  store request           (pipeline -> memory)
//             addr      byte address, ALU result (pipeline -> memory)
//             wr_data   store data, Val_Rm      (pipeline -> memory)
//             rd_data   load data to MEM/WB     (memory -> pipeline)
//             ready     low freezes the pipeline (memory -> pipeline)
//             busy      access in flight or write buffer non-empty
//  Modports : master = pipeline side, slave = memory stage side
//  Revision : 1.0  initial release
// ============================================================================
interface arm_mem_stage_sram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ready;
  logic              busy;

  modport master (
    output mem_r_en, mem_w_en, addr, wr_data,
    input  rd_data, ready, busy
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wr_data,
    output rd_data, ready, busy
  );
endinterface
`default_nettype wire

// File: rtl/arm_mem_stage_sram.sv
`default_nettype none
// ============================================================================
//  Module   : arm_mem_stage_sram
//  Purpose  : ARM pipeline MEM stage built around a wait-stated SRAM model.
//             Each access costs WAIT_CYCLES SRAM cycles plus one sampling
//             cycle; 'ready' is held low meanwhile so the pipeline freezes.
//  Ports    : clk  pipeline clock, rising edge
//             rst  synchronous reset, active-low
//             mem  arm_mem_stage_sram_if.slave (requests in, rd_data /
//                  ready / busy out)
//  Option   : `define ARM_MEM_WRITE_BUFFER_EN adds a single-entry posted
//             write buffer so a store into an empty buffer costs no stall.
//  Revision : 1.0  initial release
// ============================================================================
module arm_mem_stage_sram #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  arm_mem_stage_sram_if.slave  mem
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic              is_write_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              req;
  logic [IDX_W-1:0]  idx_d;
  logic              fsm_start;
  logic              fsm_wr_done;

  // Buffer view; tied off when the posted-write buffer is not built.
  logic              buf_valid;
  logic              buf_capture;
  logic              buf_drain;
  logic [IDX_W-1:0]  buf_idx;
  logic [DATA_W-1:0] buf_wdata;

  logic              arr_we;
  logic [IDX_W-1:0]  arr_idx;
  logic [DATA_W-1:0] arr_wdata;
  logic              ready_c;

  assign req = mem.mem_r_en | mem.mem_w_en;

  // Wrapping subtraction, drop the byte offset, keep log2(DEPTH) bits.
  assign idx_d = IDX_W'((mem.addr - ADDR_W'(BASE_ADDR)) >> 2);

  // --------------------------------------------------------------------------
  // Posted write buffer
  // --------------------------------------------------------------------------
`ifdef ARM_MEM_WRITE_BUFFER_EN
  logic              buf_valid_q;
  logic [3:0]        buf_cnt_q;
  logic [IDX_W-1:0]  buf_idx_q;
  logic [DATA_W-1:0] buf_data_q;

  // A store (including r_en & w_en together) is absorbed only in IDLE with
  // the buffer empty; anything else waits for the drain to finish.
  assign buf_capture = (state_q == ST_IDLE) & mem.mem_w_en & ~buf_valid_q;
  // The capture cycle counts as drain cycle 0, so the array is written at
  // the end of drain cycle WAIT_CYCLES-1.
  assign buf_drain   = buf_valid_q & (buf_cnt_q >= CNT_LAST);
  assign buf_valid   = buf_valid_q;
  assign buf_idx     = buf_idx_q;
  assign buf_wdata   = buf_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_cnt_q   <= '0;
      buf_idx_q   <= '0;
      buf_data_q  <= '0;
    end else if (buf_capture) begin
      buf_valid_q <= 1'b1;
      buf_cnt_q   <= 4'd1;
      buf_idx_q   <= idx_d;
      buf_data_q  <= mem.wr_data;
    end else if (buf_drain) begin
      buf_valid_q <= 1'b0;
      buf_cnt_q   <= '0;
    end else if (buf_valid_q) begin
      buf_cnt_q   <= buf_cnt_q + 4'd1;
    end
  end
`else
  assign buf_capture = 1'b0;
  assign buf_drain   = 1'b0;
  assign buf_valid   = 1'b0;
  assign buf_idx     = '0;
  assign buf_wdata   = '0;
`endif

  // Requests are taken by the FSM only when no buffered store is pending,
  // which keeps a load behind a posted store coherent.
  assign fsm_start   = (state_q == ST_IDLE) & req & ~buf_valid & ~buf_capture;
  assign fsm_wr_done = (state_q == ST_ACCESS) & (cnt_q == CNT_LAST) & is_write_q;

  // --------------------------------------------------------------------------
  // Access FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      is_write_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fsm_start) begin
            state_q    <= ST_ACCESS;
            cnt_q      <= '0;
            idx_q      <= idx_d;
            data_q     <= mem.wr_data;
            // r_en & w_en together resolves to a store.
            is_write_q <= mem.mem_w_en;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
            if (!is_write_q) begin
              rd_data_q <= mem_q[idx_q];
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
          // The request still visible here is the completed one.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // SRAM array: never reset; a write in flight at reset is dropped.
  // FSM and buffer writes cannot coincide since the FSM only starts with
  // the buffer empty and the buffer only fills while the FSM is idle.
  // --------------------------------------------------------------------------
  assign arr_we    = rst & (fsm_wr_done | buf_drain);
  assign arr_idx   = buf_drain ? buf_idx   : idx_q;
  assign arr_wdata = buf_drain ? buf_wdata : data_q;

  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem_q[arr_idx] <= arr_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      ST_IDLE: ready_c = ~req | buf_capture;
      ST_DONE: ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  assign mem.ready   = ready_c;
  assign mem.busy    = (state_q != ST_IDLE) | buf_valid;
  assign mem.rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_arm_mem_stage_sram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arm_mem_stage_sram
//  Purpose  : Directed bench for arm_mem_stage_sram. The driver pushes the
//             hand-computed stall length, rd_data and busy of each request
//             into a queue; a monitor pops and compares whenever the DUT
//             completes a request (request present with ready high).
//  Revision : 1.0  initial release
// ============================================================================
module tb_arm_mem_stage_sram;

  localparam int WAIT = 3;
  localparam int ACC  = WAIT + 1;   // stall cycles of a normal access
`ifdef ARM_MEM_WRITE_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  arm_mem_stage_sram_if #(.DATA_W(32), .ADDR_W(32)) mem_if ();

  arm_mem_stage_sram #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .DEPTH       (64),
    .BASE_ADDR   (1024),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mem (mem_if)
  );

  typedef struct {
    int          id;
    int          stall;
    logic [31:0] rd;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin
    int   stall;
    exp_t e;
    stall = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 0;
      end else if (mem_if.mem_r_en | mem_if.mem_w_en) begin
        if (!mem_if.ready) begin
          stall++;
        end else begin
          if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_completion: completion seen, none required");
          end else begin
            e = sb.pop_front();
            n_vec++;
            if (stall != e.stall) begin
              n_bad++;
              $display("FAIL vec%0d stall: got %0d cycles, required %0d", e.id, stall, e.stall);
            end
            n_vec++;
            if (mem_if.rd_data !== e.rd) begin
              n_bad++;
              $display("FAIL vec%0d rd_data: got 0x%08h, required 0x%08h", e.id, mem_if.rd_data, e.rd);
            end
            n_vec++;
            if (mem_if.busy !== e.busy) begin
              n_bad++;
              $display("FAIL vec%0d busy: got %0b, required %0b", e.id, mem_if.busy, e.busy);
            end
          end
          stall = 0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  task automatic idle_inputs();
    mem_if.mem_r_en = 1'b0;
    mem_if.mem_w_en = 1'b0;
    mem_if.addr     = '0;
    mem_if.wr_data  = '0;
  endtask

  // Present one request (from posedge+1) and hold it until the DUT completes.
  task automatic issue(input int id, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input int stall, input logic [31:0] rd);
    exp_t e;
    int   n;
    e.id    = id;
    e.stall = stall;
    e.rd    = rd;
    // A buffered store completes in IDLE with the buffer still empty.
    e.busy  = !(w && BUF_EN);
    sb.push_back(e);
    mem_if.mem_r_en = r;
    mem_if.mem_w_en = w;
    mem_if.addr     = a;
    mem_if.wr_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_if.ready && n < 50);
    if (!mem_if.ready) begin
      n_vec++; n_bad++;
      $display("FAIL vec%0d timeout: ready=0 after %0d cycles, required 1", id, n);
      finish_run();
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req_v);
    n_vec++;
    if (got !== req_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, req_v);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_ready",   32'(mem_if.ready), 32'd1);
    check("reset_busy",    32'(mem_if.busy),  32'd0);
    check("reset_rd_data", mem_if.rd_data,    32'h0);
    @(posedge clk); #1;

`ifdef ARM_MEM_WRITE_BUFFER_EN
    issue(1, 1'b0, 1'b1, 32'd1044, 32'h0000_00AB, 0,   32'h0);
    issue(2, 1'b1, 1'b0, 32'd1044, 32'h0,         6,   32'h0000_00AB);
    issue(3, 1'b0, 1'b1, 32'd1028, 32'h5,         0,   32'h0000_00AB);
    issue(4, 1'b0, 1'b1, 32'd1032, 32'h9,         2,   32'h0000_00AB);
    issue(5, 1'b1, 1'b0, 32'd1028, 32'h0,         6,   32'h5);
`else
    issue(1,  1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, ACC, 32'h0);
    issue(2,  1'b1, 1'b0, 32'd1024, 32'h0,         ACC, 32'hDEAD_BEEF);
    issue(3,  1'b0, 1'b1, 32'd1028, 32'h5,         ACC, 32'hDEAD_BEEF);
    issue(4,  1'b0, 1'b1, 32'd1032, 32'h9,         ACC, 32'hDEAD_BEEF);
    issue(5,  1'b1, 1'b0, 32'd1028, 32'h0,         ACC, 32'h5);
    issue(6,  1'b1, 1'b0, 32'd1031, 32'h0,         ACC, 32'h5);
    issue(7,  1'b0, 1'b1, 32'd1280, 32'h77,        ACC, 32'h5);
    issue(8,  1'b1, 1'b0, 32'd1024, 32'h0,         ACC, 32'h77);
    issue(9,  1'b1, 1'b0, 32'd1028, 32'h0,         ACC, 32'h5);
    issue(10, 1'b1, 1'b1, 32'd1036, 32'h11,        ACC, 32'h5);
    issue(11, 1'b1, 1'b0, 32'd1036, 32'h0,         ACC, 32'h11);
    // 1020 is below the base: offset wraps to word 63, same as 1276.
    issue(12, 1'b0, 1'b1, 32'd1020, 32'hA5,        ACC, 32'h11);
    issue(13, 1'b1, 1'b0, 32'd1276, 32'h0,         ACC, 32'hA5);
    issue(14, 1'b0, 1'b1, 32'd1040, 32'h33,        ACC, 32'hA5);

    // Store 0x22 to 1040, reset during its second ACCESS cycle.
    mem_if.mem_w_en = 1'b1;
    mem_if.addr     = 32'd1040;
    mem_if.wr_data  = 32'h22;
    @(posedge clk); #1;          // first ACCESS cycle
    @(posedge clk); #1;          // second ACCESS cycle
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;          // reset taken
    rst = 1'b1;
    @(negedge clk);
    check("midreset_ready",   32'(mem_if.ready), 32'd1);
    check("midreset_busy",    32'(mem_if.busy),  32'd0);
    check("midreset_rd_data", mem_if.rd_data,    32'h0);
    @(posedge clk); #1;

    issue(15, 1'b1, 1'b0, 32'd1040, 32'h0,         ACC, 32'h33);
    issue(16, 1'b1, 1'b0, 32'd1032, 32'h0,         ACC, 32'h9);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    finish_run();
  end

endmodule
`default_nettype wire

// File: doc/arm_mem_stage_sram.md
Name: arm_mem_stage_sram

Overview:
- Parametrised MEM stage for the ARM pipeline: a multi-cycle data-memory controller that replaces the single-cycle data memory between the EXE/MEM and MEM/WB registers.
- Takes the EXE-stage ALU result as the byte address and Rm as the store data.
- Models a wait-stated SRAM and drives a `ready` line into the pipeline freeze logic, so every stage holds while an access is in flight.
- Read data goes to the MEM/WB register unchanged.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte address width.
- DEPTH, 64, number of words in the SRAM array; power of two.
- BASE_ADDR, 1024, byte address that maps to word 0.
- WAIT_CYCLES, 3, SRAM cycles per access; legal range 1..15.

Ports:
- clk  in  1  pipeline clock; rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- mem_r_en  in  1  load request from the EXE/MEM register.
- mem_w_en  in  1  store request from the EXE/MEM register.
- addr  in  ADDR_W  byte address (ALU result).
- wr_data  in  DATA_W  store data (Val_Rm).
- rd_data  out  DATA_W  load data to the MEM/WB register.
- ready  out  1  low = freeze the whole pipeline this cycle.
- busy  out  1  an access is in flight, or the write buffer is non-empty.

Behaviour:
- Word index = ((addr - BASE_ADDR) >> 2) modulo DEPTH. addr[1:0] is ignored. Subtraction wraps modulo 2^ADDR_W; no error is raised.
- FSM states:
  - IDLE: no request, or request just sampled.
  - ACCESS: SRAM busy; counter runs 0..WAIT_CYCLES-1.
  - DONE: result available.
- IDLE -> ACCESS on a rising clk when (mem_r_en | mem_w_en). Index, wr_data and operation type are latched; counter is cleared.
- ACCESS -> DONE when counter == WAIT_CYCLES-1, otherwise counter increments.
  - Writes update the array on the DONE transition edge.
  - Reads load rd_data on that same edge.
- DONE -> IDLE unconditionally. The request still visible during DONE is the completed one and is not re-issued.
- ready (combinational):
  - 1 in DONE;
  - 1 in IDLE with no request;
  - 0 in IDLE with a request, and 0 in ACCESS.
- Latency: a request first seen in cycle T gives ready=1 in cycle T+WAIT_CYCLES+1. The stall is WAIT_CYCLES+1 cycles.
- Back-to-back requests: the next request is sampled in the IDLE cycle after DONE, so every access costs the full latency.
- mem_r_en and mem_w_en asserted together: treated as a store; rd_data is unchanged.
- rd_data holds its last loaded value until the next read completes. Stores never modify rd_data.
- Inputs are required stable while ready=0; the frozen pipeline guarantees this. The block ignores input changes while in ACCESS.
- Reset (rst=0 at a clk edge, including mid-access):
  - state becomes IDLE, counter 0, rd_data 0;
  - busy 0; write buffer is empty;
  - the pending store is discarded; array contents are preserved.
- busy = (state != IDLE) | buffer_valid.

Optional Feature:
- Macro: ARM_MEM_WRITE_BUFFER_EN.
- Defined: a single-entry posted-write buffer.
  - A store sampled in IDLE with the buffer empty is captured (index and data). ready stays 1, so the store costs zero stall cycles.
  - The buffer drains in the background over WAIT_CYCLES cycles and writes the array on its last cycle; buffer_valid then clears.
  - Any request arriving while buffer_valid=1 holds ready=0 until the drain completes, then proceeds as a normal access. This keeps a following load coherent.
  - Reset empties the buffer without writing the array.
- Undefined: all stores take the full FSM path; buffer logic is absent.

Test Plan:
- WAIT_CYCLES=3, rst=1. Store addr=1024 data=0xDEADBEEF, then load addr=1024 → store: ready low 4 cycles; load: ready low 4 cycles, then rd_data=0xDEADBEEF.
- Load addr=1028 after store 0x5 to 1028 and store 0x9 to 1032 → rd_data=0x5. Load addr=1031 → rd_data=0x5 (low bits ignored).
- Wrap: DEPTH=64, store 0x77 to addr=1024+256 → a load from 1024 returns 0x77.
- mem_r_en=mem_w_en=1, addr=1036, data=0x11, with prior rd_data=0x5 → rd_data stays 0x5; a later load of 1036 returns 0x11.
- Assert rst=0 during the 2nd ACCESS cycle of a store of 0x22 to 1040 → next cycle ready=1, busy=0, rd_data=0; a load of 1040 returns its old value.
- With ARM_MEM_WRITE_BUFFER_EN: store 0xAB to 1044, then load 1044 the next cycle → store ready stays 1; load stalls 2 drain cycles + 4 access cycles, then returns 0xAB.
